// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that fills imem and releases the CPU after a good checksum
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CHECK,
    LOAD_DONE,
    LOAD_ERROR
  } state_t;

  // Widened by one bit so a count of exactly 2**16 words still compares correctly.
  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state;
  logic        active;     // high in the four byte-consuming states
  logic [7:0]  count_hi;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] buffer;     // first three bytes of the word being assembled
  logic [7:0]  csum;       // running XOR of data bytes
  logic [15:0] full_count;
  logic        fire;

  // Ready must drop in the very cycle reset is raised, so it is gated combinationally.
  assign byte_ready = active & ~reset;
  assign fire       = byte_valid & byte_ready;
  assign full_count = {count_hi, byte_in};

  // Frame FSM: header decode, word assembly, imem write strobe, checksum verdict.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= HDR_HI;
      active     <= 1'b1;
      count_hi   <= 8'd0;
      count      <= 16'd0;
      word_idx   <= 16'd0;
      byte_cnt   <= 2'd0;
      buffer     <= 24'd0;
      csum       <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (fire) begin
        case (state)
          HDR_HI: begin
            count_hi <= byte_in;
            state    <= HDR_LO;
          end
          HDR_LO: begin
            count <= full_count;
            if ({1'b0, full_count} > MAX_W) begin
              state  <= LOAD_ERROR;
              active <= 1'b0;
              error  <= 1'b1;
            end else if (full_count == 16'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum     <= csum ^ byte_in;
            byte_cnt <= byte_cnt + 2'd1;
            buffer   <= {buffer[15:0], byte_in};
            if (byte_cnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {buffer, byte_in};
              imem_addr  <= word_idx[ADDR_WIDTH-1:0];
              word_idx   <= word_idx + 16'd1;
              if (word_idx + 16'd1 == count) begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            active <= 1'b0;
            if (byte_in == csum) begin
              state     <= LOAD_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= LOAD_ERROR;
              error <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized bench with frame-level reference model for imem_loader
module tb_imem_loader;

  localparam int AW   = 10;
  localparam int MAXW = 16;

  typedef logic [7:0] bq_t[$];

  logic          clock;
  logic          reset;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_err    = 0;

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: everything derives from the bytes accepted since reset
  logic [7:0] acc[$];
  bit         last_we;
  bit         init_done = 0;

  function automatic int frame_cnt();
    return int'({acc[0], acc[1]});
  endfunction

  // 0 = frame in progress, 1 = loaded and verified, 2 = failed
  function automatic int model_status();
    int n = acc.size();
    int c;
    logic [7:0] x;
    if (n < 2) return 0;
    c = frame_cnt();
    if (c > MAXW) return 2;
    if (n < 3 + 4 * c) return 0;
    x = 8'd0;
    for (int i = 2; i < 2 + 4 * c; i++) x ^= acc[i];
    return (acc[2 + 4 * c] == x) ? 1 : 2;
  endfunction

  function automatic int words_done();
    int n = acc.size();
    int c;
    int d;
    if (n < 2) return 0;
    c = frame_cnt();
    if (c > MAXW) return 0;
    d = n - 2;
    if (d > 4 * c) d = 4 * c;
    return d / 4;
  endfunction

  always @(posedge clock) begin
    int prev;
    bit take;
    if (reset) begin
      acc.delete();
      last_we   = 0;
      init_done = 1;
    end else if (init_done) begin
      take = byte_valid && (model_status() == 0);
      prev = words_done();
      if (take) acc.push_back(byte_in);
      last_we = take && (words_done() != prev);
    end
  end

  // Single compare process: every output against the model on every cycle after the first reset.
  always @(negedge clock) begin
    int st;
    int k;
    int idx;
    logic [31:0] ew;
    if (init_done) begin
      st = model_status();
      k  = words_done();
      ew = 32'd0;
      if (k > 0) begin
        idx = 2 + 4 * (k - 1);
        ew  = {acc[idx], acc[idx+1], acc[idx+2], acc[idx+3]};
      end
      chk("byte_ready", 32'(byte_ready), 32'(!reset && st == 0));
      chk("imem_we",    32'(imem_we),    32'(last_we));
      chk("imem_addr",  32'(imem_addr),  (k > 0) ? 32'((k - 1) & ((1 << AW) - 1)) : 32'd0);
      chk("imem_wdata", imem_wdata,      ew);
      chk("cpu_reset",  32'(cpu_reset),  32'(st != 1));
      chk("done",       32'(done),       32'(st == 1));
      chk("error",      32'(error),      32'(st == 2));
    end
  end

  // Write log for literal end-of-frame expectations.
  logic [AW-1:0] wl_addr[$];
  logic [31:0]   wl_data[$];
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wl_addr.push_back(imem_addr);
      wl_data.push_back(imem_wdata);
    end
  end

  // ---------------- stimulus
  task automatic send(input bq_t q, input int gap);
    int tries;
    logic fire;
    foreach (q[i]) begin
      tries = 0;
      forever begin
        byte_valid = ($urandom_range(0, 99) >= gap);
        byte_in    = byte_valid ? q[i] : 8'($urandom);
        @(negedge clock);
        fire = byte_valid & byte_ready;
        @(posedge clock);
        #1;
        if (fire) break;
        tries++;
        if (tries > 200) begin
          n_checks++;
          n_err++;
          $display("FAIL send_timeout byte=%0d got=not-accepted exp=accepted", i);
          byte_valid = 1'b0;
          return;
        end
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic junk(input int cyc);
    repeat (cyc) begin
      byte_valid = 1'($urandom_range(0, 1));
      byte_in    = 8'($urandom);
      @(posedge clock);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    junk(cyc);
    reset = 1'b0;
    wl_addr.delete();
    wl_data.delete();
  endtask

  task automatic check_nominal(input string tag);
    chk({tag, "_nwr"}, 32'(wl_addr.size()), 32'd2);
    if (wl_addr.size() >= 2) begin
      chk({tag, "_a0"}, 32'(wl_addr[0]), 32'd0);
      chk({tag, "_d0"}, wl_data[0], 32'h2880_0001);
      chk({tag, "_a1"}, 32'(wl_addr[1]), 32'd1);
      chk({tag, "_d1"}, wl_data[1], 32'h0000_0000);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_err"}, 32'(error), 32'd0);
  endtask

  bq_t nom;
  bq_t bad;
  bq_t f;

  initial begin
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    nom = '{8'h00, 8'h02, 8'h28, 8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA9};
    bad = nom;
    bad[10] = 8'hAA;

    // pin the model with hand-computed frames
    acc = nom;
    chk("model_nom_status", 32'(model_status()), 32'd1);
    chk("model_nom_words",  32'(words_done()),   32'd2);
    acc = bad;
    chk("model_bad_status", 32'(model_status()), 32'd2);
    acc = '{8'h00, 8'h11};
    chk("model_big_status", 32'(model_status()), 32'd2);
    acc = '{8'h00, 8'h00, 8'h00};
    chk("model_empty_status", 32'(model_status()), 32'd1);
    acc.delete();

    // reset state
    reset = 1'b1;
    junk(2);
    chk("rst_ready",  32'(byte_ready), 32'd0);
    chk("rst_cpurst", 32'(cpu_reset),  32'd1);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_err",    32'(error),      32'd0);
    chk("rst_we",     32'(imem_we),    32'd0);
    reset = 1'b0;
    wl_addr.delete();
    wl_data.delete();
    #1;
    chk("post_rst_ready", 32'(byte_ready), 32'd1);

    // nominal, back-to-back
    send(nom, 0);
    check_nominal("nom");

    // nominal with gaps, then ignored trailing bytes
    do_reset(1);
    send(nom, 50);
    check_nominal("gap");
    repeat (6) begin
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      @(posedge clock);
      #1;
    end
    byte_valid = 1'b0;
    chk("post_done_nwr",  32'(wl_addr.size()), 32'd2);
    chk("post_done_done", 32'(done), 32'd1);

    // bad checksum
    do_reset(2);
    send(bad, 20);
    chk("bad_nwr",    32'(wl_addr.size()), 32'd2);
    chk("bad_err",    32'(error), 32'd1);
    chk("bad_done",   32'(done), 32'd0);
    chk("bad_cpurst", 32'(cpu_reset), 32'd1);
    chk("bad_ready",  32'(byte_ready), 32'd0);

    // empty image
    do_reset(1);
    send('{8'h00, 8'h00, 8'h00}, 0);
    chk("empty_nwr",    32'(wl_addr.size()), 32'd0);
    chk("empty_done",   32'(done), 32'd1);
    chk("empty_cpurst", 32'(cpu_reset), 32'd0);

    // oversized count
    do_reset(1);
    send('{8'h00, 8'h11}, 0);
    chk("big_err",   32'(error), 32'd1);
    chk("big_ready", 32'(byte_ready), 32'd0);
    junk(4);
    chk("big_nwr",   32'(wl_addr.size()), 32'd0);

    // largest accepted count
    do_reset(1);
    f = '{8'h00, 8'h10};
    begin
      logic [7:0] x = 8'd0;
      logic [7:0] b;
      for (int i = 0; i < 64; i++) begin
        b = 8'($urandom);
        x ^= b;
        f.push_back(b);
      end
      f.push_back(x);
    end
    send(f, 10);
    chk("max_nwr",  32'(wl_addr.size()), 32'd16);
    if (wl_addr.size() == 16) chk("max_last_addr", 32'(wl_addr[15]), 32'd15);
    chk("max_done", 32'(done), 32'd1);

    // reset mid-load
    do_reset(1);
    send('{8'h00, 8'h02, 8'h28, 8'h80, 8'h00}, 0);
    chk("mid_nwr", 32'(wl_addr.size()), 32'd0);
    do_reset(1);
    send(nom, 0);
    check_nominal("mid");

    // randomized frames
    for (int t = 0; t < 40; t++) begin
      int c;
      int cut;
      bit over;
      logic [7:0] x;
      logic [7:0] b;
      do_reset($urandom_range(1, 2));
      over = ($urandom_range(0, 9) == 0);
      c = over ? $urandom_range(MAXW + 1, 300) : $urandom_range(0, MAXW);
      f.delete();
      f.push_back(8'(c >> 8));
      f.push_back(8'(c));
      if (!over) begin
        x = 8'd0;
        for (int i = 0; i < 4 * c; i++) begin
          b = 8'($urandom);
          x ^= b;
          f.push_back(b);
        end
        if ($urandom_range(0, 4) == 0) x ^= 8'($urandom_range(1, 255));
        f.push_back(x);
      end
      if ($urandom_range(0, 7) == 0) begin
        cut = $urandom_range(0, f.size() - 1);
        while (f.size() > cut) void'(f.pop_back());
        send(f, $urandom_range(0, 70));
        junk(2);
      end else begin
        send(f, $urandom_range(0, 70));
        junk(3);
        chk("rnd_nwr", 32'(wl_addr.size()), over ? 32'd0 : 32'(c));
      end
    end

    do_reset(1);
    junk(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
